// File: rtl/dmem_param_if.sv
// ---------------------------------------------------------------------------
// dmem_param_if
// Bus between the MA stage (master) and the parametrised data memory (slave).
//
// Signals:
//   read         [3] read enable, [2:0] funct3 (LB/LH/LW/LBU/LHU)
//   write        [2] write enable, [1:0] funct3 (SB/SH/SW)
//   address      byte address
//   writedata    store data (low byte/half used for SB/SH)
//   readdata     extended load result
//   busywait     stall request towards the pipeline
//   access_fault request rejected, nothing was performed
// ---------------------------------------------------------------------------
interface dmem_param_if;
    logic [3:0]  read;
    logic [2:0]  write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
    logic        access_fault;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait, access_fault
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait, access_fault
    );
endinterface

// File: rtl/dmem_param.sv
// ---------------------------------------------------------------------------
// dmem_param
// Word-organised little-endian data memory for the MA stage with a
// configurable depth and access latency. Serves LB/LH/LW/LBU/LHU and
// SB/SH/SW, raising busywait while an access is in flight and access_fault
// for misaligned, out-of-range, reserved or read+write requests.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (byte range 0 .. 4*DEPTH_WORDS-1)
//   LATENCY      cycles busywait stays high per legal access (>= 1)
//
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous, active-low
//   bus          dmem_param_if.slave (read/write/address/writedata in,
//                readdata/busywait/access_fault out)
//
// Optional feature (macro DMEM_DEBUG_EN):
//   DEBUG_DATA       full word at the last completed access address
//   DEBUG_READ_ACC   one-cycle pulse in DONE after a read
//   DEBUG_WRITE_ACC  one-cycle pulse in DONE after a write
// ---------------------------------------------------------------------------
module dmem_param #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic          clock,
    input  logic          reset,
    dmem_param_if.slave   bus
`ifdef DMEM_DEBUG_EN
    ,
    output logic [31:0]   DEBUG_DATA,
    output logic          DEBUG_READ_ACC,
    output logic          DEBUG_WRITE_ACC
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] COUNT_LOAD = CW'(LATENCY - 1);
    localparam logic [32:0]   ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_nextCount;

    logic [AW+1:0]  r_addr;
    logic [31:0]    r_wdata;
    logic           r_isWrite;
    logic           r_isUnsigned;
    logic [1:0]     r_size;
    logic [31:0]    r_readData;

    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_rdReq;
    logic           w_wrReq;
    logic           w_request;
    logic           w_both;
    logic           w_reserved;
    logic           w_misaligned;
    logic           w_outOfRange;
    logic           w_fault;
    logic           w_accept;
    logic [1:0]     w_reqSize;

    logic [AW+1:0]  w_accAddr;
    logic [31:0]    w_accWdata;
    logic           w_accIsWrite;
    logic           w_accUnsigned;
    logic [1:0]     w_accSize;
    logic           w_doAccess;

    logic [AW-1:0]  w_wordIdx;
    logic [31:0]    w_oldWord;
    logic [7:0]     w_loadByte;
    logic [15:0]    w_loadHalf;
    logic [31:0]    w_loadResult;
    logic [3:0]     w_laneMask;
    logic [31:0]    w_laneData;
    logic [31:0]    w_mergedWord;

    // Request classification. For a read+write collision the size field is
    // taken from the write, but that request faults regardless.
    assign w_rdReq      = bus.read[3];
    assign w_wrReq      = bus.write[2];
    assign w_request    = w_rdReq | w_wrReq;
    assign w_both       = w_rdReq & w_wrReq;
    assign w_reqSize    = w_wrReq ? bus.write[1:0] : bus.read[1:0];
    assign w_reserved   = (w_rdReq && (bus.read[2:0] == 3'b011 ||
                                       bus.read[2:0] == 3'b110 ||
                                       bus.read[2:0] == 3'b111)) ||
                          (w_wrReq && bus.write[1:0] == 2'b11);
    assign w_misaligned = (w_reqSize == 2'b01 && bus.address[0]) ||
                          (w_reqSize == 2'b10 && bus.address[1:0] != 2'b00);
    assign w_outOfRange = {1'b0, bus.address} >= ADDR_LIMIT;

    // Faults and acceptance are only meaningful in IDLE; BUSY and DONE ignore
    // the bus entirely so a held request is not re-run during DONE.
    assign w_fault  = (r_state == IDLE) && w_request &&
                      (w_both || w_reserved || w_misaligned || w_outOfRange);
    assign w_accept = (r_state == IDLE) && w_request && !w_fault;

    assign bus.busywait     = w_accept || (r_state == BUSY);
    assign bus.access_fault = w_fault;
    assign bus.readdata     = r_readData;

    // The access normally runs from the captured registers. With LATENCY=1
    // there is no BUSY cycle, so it completes at the capture edge straight
    // from the bus inputs.
    always_comb begin
        if (r_state == IDLE) begin
            w_accAddr     = bus.address[AW+1:0];
            w_accWdata    = bus.writedata;
            w_accIsWrite  = w_wrReq;
            w_accUnsigned = bus.read[2];
            w_accSize     = w_reqSize;
        end else begin
            w_accAddr     = r_addr;
            w_accWdata    = r_wdata;
            w_accIsWrite  = r_isWrite;
            w_accUnsigned = r_isUnsigned;
            w_accSize     = r_size;
        end
    end

    // Completion happens on the edge that leaves the last BUSY cycle, which
    // keeps busywait high for exactly LATENCY cycles including the request.
    assign w_doAccess = ((r_state == BUSY) && (r_count == CW'(1))) ||
                        ((LATENCY == 1) && w_accept);

    assign w_wordIdx = w_accAddr[AW+1:2];
    assign w_oldWord = r_mem[w_wordIdx];

    // Load path: pick the lane, then sign- or zero-extend.
    always_comb begin
        case (w_accAddr[1:0])
            2'd0:    w_loadByte = w_oldWord[7:0];
            2'd1:    w_loadByte = w_oldWord[15:8];
            2'd2:    w_loadByte = w_oldWord[23:16];
            default: w_loadByte = w_oldWord[31:24];
        endcase
        w_loadHalf = w_accAddr[1] ? w_oldWord[31:16] : w_oldWord[15:0];
        case (w_accSize)
            2'b00:   w_loadResult = w_accUnsigned ? {24'd0, w_loadByte}
                                                  : {{24{w_loadByte[7]}}, w_loadByte};
            2'b01:   w_loadResult = w_accUnsigned ? {16'd0, w_loadHalf}
                                                  : {{16{w_loadHalf[15]}}, w_loadHalf};
            default: w_loadResult = w_oldWord;
        endcase
    end

    // Store path: replicate the data across lanes and merge only the enabled
    // lanes into the old word, preserving the others.
    always_comb begin
        case (w_accSize)
            2'b00: begin
                w_laneMask = 4'b0001 << w_accAddr[1:0];
                w_laneData = {4{w_accWdata[7:0]}};
            end
            2'b01: begin
                w_laneMask = w_accAddr[1] ? 4'b1100 : 4'b0011;
                w_laneData = {2{w_accWdata[15:0]}};
            end
            default: begin
                w_laneMask = 4'b1111;
                w_laneData = w_accWdata;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            w_mergedWord[8*i +: 8] = w_laneMask[i] ? w_laneData[8*i +: 8]
                                                   : w_oldWord[8*i +: 8];
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = (LATENCY == 1) ? DONE : BUSY;
                    w_nextCount = COUNT_LOAD;
                end
            end
            BUSY: begin
                w_nextCount = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
                w_nextCount = '0;
            end
        endcase
    end

    // State, captured request and load result. Reset wins over a completing
    // access, so an access interrupted by reset never updates readdata.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_isWrite    <= 1'b0;
            r_isUnsigned <= 1'b0;
            r_size       <= 2'b00;
            r_readData   <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_accept) begin
                r_addr       <= bus.address[AW+1:0];
                r_wdata      <= bus.writedata;
                r_isWrite    <= w_wrReq;
                r_isUnsigned <= bus.read[2];
                r_size       <= w_reqSize;
            end
            if (w_doAccess && !w_accIsWrite) begin
                r_readData <= w_loadResult;
            end
        end
    end

    // Storage array; contents survive reset, but a write pending when reset
    // arrives is dropped.
    always_ff @(posedge clock) begin
        if (reset && w_doAccess && w_accIsWrite) begin
            r_mem[w_wordIdx] <= w_mergedWord;
        end
    end

`ifdef DMEM_DEBUG_EN
    logic [31:0] r_debugData;
    logic        r_debugRead;
    logic        r_debugWrite;

    // Pulses are set on the completion edge, so they are high exactly in DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_debugData  <= '0;
            r_debugRead  <= 1'b0;
            r_debugWrite <= 1'b0;
        end else begin
            r_debugRead  <= w_doAccess && !w_accIsWrite;
            r_debugWrite <= w_doAccess && w_accIsWrite;
            if (w_doAccess) begin
                r_debugData <= w_accIsWrite ? w_mergedWord : w_oldWord;
            end
        end
    end

    assign DEBUG_DATA      = r_debugData;
    assign DEBUG_READ_ACC  = r_debugRead;
    assign DEBUG_WRITE_ACC = r_debugWrite;
`endif

endmodule

// File: tb/tb_dmem_param.sv
// ---------------------------------------------------------------------------
// tb_dmem_param
// Self-checking bench for dmem_param (DEPTH_WORDS=256, LATENCY=3): a table
// of directed accesses with hand-computed results, plus hand-written
// sequences for a request held through DONE and reset during BUSY.
// ---------------------------------------------------------------------------
module tb_dmem_param;

    localparam int LAT = 3;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    dmem_param_if bus ();

`ifdef DMEM_DEBUG_EN
    logic [31:0] dbgData;
    logic        dbgRead;
    logic        dbgWrite;
`endif

    dmem_param #(
        .DEPTH_WORDS(256),
        .LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef DMEM_DEBUG_EN
        ,
        .DEBUG_DATA(dbgData),
        .DEBUG_READ_ACC(dbgRead),
        .DEBUG_WRITE_ACC(dbgWrite)
`endif
    );

    // Free-running 10-time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          expBusy;
        logic        expFault;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int expBusy, input logic expFault, input logic [31:0] expData);
        vec_t v;
        v.name     = name;
        v.rd       = rd;
        v.wr       = wr;
        v.addr     = addr;
        v.wdata    = wdata;
        v.expBusy  = expBusy;
        v.expFault = expFault;
        v.expData  = expData;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        bus.read      = 4'b0000;
        bus.write     = 3'b000;
        bus.address   = 32'd0;
        bus.writedata = 32'd0;
    endtask

    // Counts busywait-high cycles from the current sample point until the
    // DONE cycle (busywait low), bounded so a stuck DUT cannot hang the run.
    task automatic waitDone(input bit dropRequest, output int busy);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.busywait) break;
            busy++;
            @(posedge clock);
            #1;
            if (dropRequest) clearInputs();
        end
        if (busy >= 20) begin
            failures++;
            $display("[TB] FAIL busywait_timeout actual=%0d expected=<20", busy);
        end
    endtask

    // Issues one request in an IDLE cycle, records the fault flag of the
    // request cycle, the number of busy cycles and readdata in DONE, then
    // returns one sample point into the following IDLE cycle.
    task automatic applyStimulus(input logic [3:0] rd, input logic [2:0] wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int busy, output logic fault,
                                 output logic [31:0] rdata);
        @(negedge clock);
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = addr;
        bus.writedata = wdata;
        #1;
        fault = bus.access_fault;
        waitDone(1'b1, busy);
        rdata = bus.readdata;
        clearInputs();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int          busy;
        int          busy2;
        logic        fault;
        logic [31:0] rdata;

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        clearInputs();

        // Directed table: name, read, write, address, writedata,
        // busy cycles, fault, readdata observed in DONE (or unchanged).
        addVec("sw_clr10",   4'b0000, 3'b110, 32'h10,  32'h0000_0000, LAT, 1'b0, 32'h0000_0000);
        addVec("sw_04",      4'b0000, 3'b110, 32'h04,  32'hAABB_CCDD, LAT, 1'b0, 32'h0000_0000);
        addVec("lw_04",      4'b1010, 3'b000, 32'h04,  32'h0,         LAT, 1'b0, 32'hAABB_CCDD);
        addVec("sw_08",      4'b0000, 3'b110, 32'h08,  32'h1122_3344, LAT, 1'b0, 32'hAABB_CCDD);
        addVec("sb_09",      4'b0000, 3'b100, 32'h09,  32'h1234_5680, LAT, 1'b0, 32'hAABB_CCDD);
        addVec("lw_08",      4'b1010, 3'b000, 32'h08,  32'h0,         LAT, 1'b0, 32'h1122_8044);
        addVec("lb_09",      4'b1000, 3'b000, 32'h09,  32'h0,         LAT, 1'b0, 32'hFFFF_FF80);
        addVec("lbu_09",     4'b1100, 3'b000, 32'h09,  32'h0,         LAT, 1'b0, 32'h0000_0080);
        addVec("lb_08",      4'b1000, 3'b000, 32'h08,  32'h0,         LAT, 1'b0, 32'h0000_0044);
        addVec("lh_0a",      4'b1001, 3'b000, 32'h0A,  32'h0,         LAT, 1'b0, 32'h0000_1122);
        addVec("sw_0c",      4'b0000, 3'b110, 32'h0C,  32'h5566_7788, LAT, 1'b0, 32'h0000_1122);
        addVec("sh_0e",      4'b0000, 3'b101, 32'h0E,  32'hDEAD_BEEF, LAT, 1'b0, 32'h0000_1122);
        addVec("lh_0e",      4'b1001, 3'b000, 32'h0E,  32'h0,         LAT, 1'b0, 32'hFFFF_BEEF);
        addVec("lhu_0e",     4'b1101, 3'b000, 32'h0E,  32'h0,         LAT, 1'b0, 32'h0000_BEEF);
        addVec("lw_0c",      4'b1010, 3'b000, 32'h0C,  32'h0,         LAT, 1'b0, 32'hBEEF_7788);
        addVec("flt_lw06",   4'b1010, 3'b000, 32'h06,  32'h0,         0,   1'b1, 32'hBEEF_7788);
        addVec("flt_sh03",   4'b0000, 3'b101, 32'h03,  32'h0000_FFFF, 0,   1'b1, 32'hBEEF_7788);
        addVec("flt_lw400",  4'b1010, 3'b000, 32'h400, 32'h0,         0,   1'b1, 32'hBEEF_7788);
        addVec("flt_rdwr",   4'b1010, 3'b110, 32'h04,  32'h0,         0,   1'b1, 32'hBEEF_7788);
        addVec("flt_rdrsv",  4'b1011, 3'b000, 32'h00,  32'h0,         0,   1'b1, 32'hBEEF_7788);
        addVec("flt_wrrsv",  4'b0000, 3'b111, 32'h04,  32'h0,         0,   1'b1, 32'hBEEF_7788);
        addVec("lw_04_kept", 4'b1010, 3'b000, 32'h04,  32'h0,         LAT, 1'b0, 32'hAABB_CCDD);
        addVec("sw_3fc",     4'b0000, 3'b110, 32'h3FC, 32'hCAFE_F00D, LAT, 1'b0, 32'hAABB_CCDD);
        addVec("lw_3fc",     4'b1010, 3'b000, 32'h3FC, 32'h0,         LAT, 1'b0, 32'hCAFE_F00D);
        addVec("lh_3fe",     4'b1001, 3'b000, 32'h3FE, 32'h0,         LAT, 1'b0, 32'hFFFF_CAFE);

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_busywait", {31'd0, bus.busywait},     32'd0);
        checkOutput("rst_fault",    {31'd0, bus.access_fault}, 32'd0);
        checkOutput("rst_readdata", bus.readdata,              32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Table-driven accesses.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                          busy, fault, rdata);
            checkOutput({vecs[i].name, "_busy"},  busy,              vecs[i].expBusy);
            checkOutput({vecs[i].name, "_fault"}, {31'd0, fault},    {31'd0, vecs[i].expFault});
            checkOutput({vecs[i].name, "_data"},  rdata,             vecs[i].expData);
        end

        // Request held through DONE: one access, then a fresh access starts
        // in the cycle after DONE.
        @(negedge clock);
        bus.read    = 4'b1010;
        bus.address = 32'h04;
        #1;
        waitDone(1'b0, busy);
        checkOutput("hold_busy1",    busy,                     LAT);
        checkOutput("hold_done_bw",  {31'd0, bus.busywait},    32'd0);
        checkOutput("hold_data1",    bus.readdata,             32'hAABB_CCDD);
        @(posedge clock);
        #1;
        checkOutput("hold_restart",  {31'd0, bus.busywait},    32'd1);
        waitDone(1'b1, busy2);
        checkOutput("hold_busy2",    busy2,                    LAT);
        checkOutput("hold_data2",    bus.readdata,             32'hAABB_CCDD);
        clearInputs();
        @(posedge clock);
        #1;

        // Reset on the edge that would complete SW 0x12345678 @0x10.
        @(negedge clock);
        bus.write     = 3'b110;
        bus.address   = 32'h10;
        bus.writedata = 32'h1234_5678;
        #1;
        checkOutput("rstb_req_bw",   {31'd0, bus.busywait},    32'd1);
        @(posedge clock);
        #1;
        clearInputs();
        @(posedge clock);
        #1;
        checkOutput("rstb_busy_bw",  {31'd0, bus.busywait},    32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rstb_bw",       {31'd0, bus.busywait},    32'd0);
        checkOutput("rstb_fault",    {31'd0, bus.access_fault}, 32'd0);
        checkOutput("rstb_readdata", bus.readdata,             32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(4'b1010, 3'b000, 32'h04, 32'h0, busy, fault, rdata);
        checkOutput("post_lw04",     rdata,                    32'hAABB_CCDD);
        applyStimulus(4'b1010, 3'b000, 32'h10, 32'h0, busy, fault, rdata);
        checkOutput("post_lw10_busy", busy,                    LAT);
        checkOutput("post_lw10",     rdata,                    32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
